// File: rtl/serial_word_compare.sv
// -----------------------------------------------------------------------------
// serial_word_compare
//
// Bit-serial unsigned magnitude/equality comparator. Two operands arrive MSB
// first, one bit pair per accepted cycle. Once WIDTH bit pairs have been
// consumed the block raises a one-cycle `done` strobe together with exactly
// one of eq/gt/lt. Results hold until the next accepted `start`.
//
// Handshake: a bit pair is consumed on a rising edge where the FSM is in
// COMPARE and bit_valid=1. There is no back-pressure. `start` is only
// honoured in IDLE. Cycles with bit_valid=0 in COMPARE are bubbles.
//
// Parameters:
//   WIDTH      operand width in bits, 2..32 (default 4)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a new comparison (IDLE only)
//   bit_valid  a_bit/b_bit carry a valid pair this cycle
//   a_bit      operand A, serial, MSB first
//   b_bit      operand B, serial, MSB first
//   busy       high while in COMPARE
//   done       one-cycle strobe; results valid from this cycle
//   eq         A == B
//   gt         A >  B (unsigned)
//   lt         A <  B (unsigned)
//
// Build option:
//   SERIAL_WORD_COMPARE_EARLY_EXIT_EN  when defined, the first differing bit
//   pair finishes the comparison immediately. The sender must stop driving
//   the rest of that word; extra bit_valid in DONE/IDLE is ignored.
//
// The FSM state is held in `state_q` (type state_t) for checker binding.
// -----------------------------------------------------------------------------
module serial_word_compare #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic eq,
   output logic gt,
   output logic lt
);

   // One extra bit so the counter can never wrap inside a word.
   localparam int CW = $clog2(WIDTH) + 1;

`ifdef SERIAL_WORD_COMPARE_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          decided_q, decided_d;
   logic          a_gt_q, a_gt_d;
   logic          eq_q, eq_d;
   logic          gt_q, gt_d;
   logic          lt_q, lt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          last_bit;
   logic          first_diff;

   assign last_bit   = (cnt_q == CW'(WIDTH - 1));
   // First differing pair of this word (later differences are irrelevant
   // because the MSB-most difference decides the magnitude).
   assign first_diff = !decided_q && (a_bit ^ b_bit);

   // ---------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      a_gt_d    = a_gt_q;
      eq_d      = eq_q;
      gt_d      = gt_q;
      lt_d      = lt_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = COMPARE;
               cnt_d     = '0;
               decided_d = 1'b0;
               a_gt_d    = 1'b0;
               eq_d      = 1'b0;
               gt_d      = 1'b0;
               lt_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end

         COMPARE: begin
            busy_d = 1'b1;
            if (bit_valid) begin
               cnt_d = cnt_q + CW'(1);
               if (first_diff) begin
                  decided_d = 1'b1;
                  a_gt_d    = a_bit;
               end
               // decided_d/a_gt_d already include this edge's bit pair, so a
               // difference in the final bit is reflected in the result.
               if (last_bit || (EARLY_EXIT && first_diff)) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  if (decided_d) begin
                     eq_d = 1'b0;
                     gt_d = a_gt_d;
                     lt_d = ~a_gt_d;
                  end else begin
                     eq_d = 1'b1;
                     gt_d = 1'b0;
                     lt_d = 1'b0;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         a_gt_q    <= 1'b0;
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         a_gt_q    <= a_gt_d;
         eq_q      <= eq_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign eq   = eq_q;
   assign gt   = gt_q;
   assign lt   = lt_q;

endmodule
